// File: rtl/led_pattern_ctrl.sv
`timescale 1ns/1ps
// Purpose: multi-channel LED driver; each channel is off, on, blinking or following its switch.
// Latency: mode write -> led 2 edges; switch -> led 3 edges; blink_tick -> blink led toggle 1 edge.
// Backpressure: none; the prescaler free-runs and mode writes are accepted every cycle.
//
// Optional feature macro: LED_PWM_EN (global PWM brightness gating of every channel).
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   s           asynchronous switch inputs, one per channel
//   wr_en       mode-write strobe
//   wr_addr     channel index to write; indices >= N_LED are dropped
//   wr_mode     00 off, 01 on, 10 blink, 11 follow-switch
//   brightness  global PWM duty (only used with LED_PWM_EN)
//   blink_tick  one-cycle pulse on every blink phase toggle
//   led         registered LED drive, active-high
module led_pattern_ctrl #(
    parameter int N_LED     = 3,
    parameter int BLINK_DIV = 10_000_000,
    parameter int PWM_BITS  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_LED-1:0]         s,
    input  logic                     wr_en,
    input  logic [$clog2(N_LED)-1:0] wr_addr,
    input  logic [1:0]               wr_mode,
    input  logic [PWM_BITS-1:0]      brightness,
    output logic                     blink_tick,
    output logic [N_LED-1:0]         led
);

    localparam int            CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_ON     = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_SWITCH = 2'b11
    } mode_e;

    // Prescaler state
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             tick_q, tick_d;

    // Per-channel mode registers
    mode_e            mode_q [N_LED];
    mode_e            mode_d [N_LED];

    // Switch synchronisers
    logic [N_LED-1:0] sync1_q, sync2_q;

    // Output path
    logic [N_LED-1:0] raw;
    logic [N_LED-1:0] led_q, led_d;
    logic             pwm_on;

    // Shared prescaler: one phase toggle every BLINK_DIV cycles, never stalled by modes.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        tick_d  = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            tick_d  = 1'b1;
        end
    end

    // Mode write decode; an out-of-range address matches no channel and is dropped.
    always_comb begin
        for (int i = 0; i < N_LED; i++) begin
            mode_d[i] = mode_q[i];
            if (wr_en && (int'(wr_addr) == i)) begin
                mode_d[i] = mode_e'(wr_mode);
            end
        end
    end

    // Raw per-channel drive from the current mode. Every blink channel uses the same
    // shared phase, so channels switched into blink mid-period stay aligned.
    always_comb begin
        raw = '0;
        for (int i = 0; i < N_LED; i++) begin
            case (mode_q[i])
                MODE_OFF:    raw[i] = 1'b0;
                MODE_ON:     raw[i] = 1'b1;
                MODE_BLINK:  raw[i] = phase_q;
                MODE_SWITCH: raw[i] = sync2_q[i];
                default:     raw[i] = 1'b0;
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;

    // Free-running duty counter; brightness is compared live so it can change mid-period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    assign pwm_on = (pwm_cnt_q < brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_on            = 1'b1;
`endif

    assign led_d = raw & {N_LED{pwm_on}};

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            tick_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            led_q   <= '0;
            for (int i = 0; i < N_LED; i++) begin
                mode_q[i] <= MODE_OFF;
            end
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
            sync1_q <= s;
            sync2_q <= sync1_q;
            led_q   <= led_d;
            for (int i = 0; i < N_LED; i++) begin
                mode_q[i] <= mode_d[i];
            end
        end
    end

    assign blink_tick = tick_q;
    assign led        = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int PB  = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (N_LED=4)
    logic       reset;
    logic [3:0] s;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [1:0] wr_mode;
    logic [1:0] brightness;
    logic       blink_tick;
    logic [3:0] led;

    // Second DUT (N_LED=3) for the out-of-range address case
    logic [2:0] s3;
    logic       wr_en3;
    logic [1:0] wr_addr3;
    logic [1:0] wr_mode3;
    logic [1:0] brightness3;
    logic       tick3;
    logic [2:0] led3;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         n;            // non-reset edges since the last reset
    logic [1:0] m_mode [N];
    logic [3:0] sq [$];       // switch values seen at the last two edges, oldest first
    logic [3:0] exp_led;
    logic       exp_tick;

    led_pattern_ctrl #(.N_LED(N), .BLINK_DIV(DIV), .PWM_BITS(PB)) dut (
        .clk(clk), .reset(reset), .s(s), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mode(wr_mode), .brightness(brightness), .blink_tick(blink_tick), .led(led)
    );

    led_pattern_ctrl #(.N_LED(3), .BLINK_DIV(DIV), .PWM_BITS(PB)) dut3 (
        .clk(clk), .reset(reset), .s(s3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_mode(wr_mode3), .brightness(brightness3), .blink_tick(tick3), .led(led3)
    );

    // Advance one clock edge and update the model from the inputs sampled at that edge.
    // Phase and tick come from plain arithmetic on the edge count since reset.
    task automatic clock_edge();
        logic [3:0] sync_now;
        logic [3:0] raw;
        bit         en;
        @(posedge clk);
        if (!reset) begin
            n        = 0;
            for (int i = 0; i < N; i++) m_mode[i] = 2'b00;
            sq       = '{4'h0, 4'h0};
            exp_led  = '0;
            exp_tick = 1'b0;
        end else begin
            sync_now = sq[0];
            void'(sq.pop_front());
            sq.push_back(s);
            for (int i = 0; i < N; i++) begin
                case (m_mode[i])
                    2'b00:   raw[i] = 1'b0;
                    2'b01:   raw[i] = 1'b1;
                    2'b10:   raw[i] = ((n / DIV) % 2) == 1;
                    default: raw[i] = sync_now[i];
                endcase
            end
            en = 1'b1;
`ifdef LED_PWM_EN
            en = (n % (1 << PB)) < int'(brightness);
`endif
            exp_led  = en ? raw : 4'h0;
            exp_tick = (n % DIV) == (DIV - 1);
            n++;
            if (wr_en && int'(wr_addr) < N) m_mode[wr_addr] = wr_mode;
        end
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        wr_en  = 1'b0;
        wr_en3 = 1'b0;
        s      = '0;
        clock_edge();
        clock_edge();
        reset  = 1'b1;
    endtask

    task automatic write_mode(input logic [1:0] ch, input logic [1:0] md);
        wr_en   = 1'b1;
        wr_addr = ch;
        wr_mode = md;
        clock_edge();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 2'($urandom_range(0, 3));
        wr_mode = 2'b01;
        s       = 4'hF;
        for (int k = 0; k < 3; k++) begin
            clock_edge();
            checks++;
            if (led !== 4'h0 || blink_tick !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d led=%h tick=%b expected led=0 tick=0", k, led, blink_tick);
            end
        end
        reset = 1'b1;
        wr_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            clock_edge();
            checks++;
            if (led !== 4'h0 || led !== exp_led) begin
                failures++;
                $display("FAIL reset_modes cyc=%0d led=%h expected=0", k, led);
            end
        end
    endtask

    task automatic test_blink();
        int   ticks = 0;
        logic prev_tick, prev_led0;
        do_reset();
        write_mode(2'd0, 2'b10);
        prev_tick = blink_tick;
        prev_led0 = led[0];
        for (int k = 0; k < 24; k++) begin
            clock_edge();
            checks++;
            if (led !== exp_led || blink_tick !== exp_tick) begin
                failures++;
                $display("FAIL blink_model cyc=%0d led=%h tick=%b expected led=%h tick=%b",
                         k, led, blink_tick, exp_led, exp_tick);
            end
            checks++;
            if ((led[0] !== prev_led0) !== prev_tick) begin
                failures++;
                $display("FAIL blink_toggle cyc=%0d led0=%b prev_led0=%b prev_tick=%b",
                         k, led[0], prev_led0, prev_tick);
            end
            if (blink_tick) ticks++;
            prev_tick = blink_tick;
            prev_led0 = led[0];
        end
        checks++;
        if (ticks != 6) begin
            failures++;
            $display("FAIL blink_tick_count got=%0d expected=6", ticks);
        end
    endtask

    task automatic test_follow();
        logic [3:0] want [3] = '{4'h0, 4'h0, 4'h4};
        do_reset();
        write_mode(2'd2, 2'b11);
        clock_edge();
        clock_edge();
        s[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clock_edge();
            checks++;
            if (led !== want[k] || led !== exp_led) begin
                failures++;
                $display("FAIL follow_latency edge=%0d led=%h expected=%h", k + 1, led, want[k]);
            end
        end
        s = 4'h0;
    endtask

    task automatic test_addr_range();
        do_reset();
        wr_en3   = 1'b1;
        wr_addr3 = 2'd3;
        wr_mode3 = 2'b01;
        clock_edge();
        wr_en3 = 1'b0;
        clock_edge();
        clock_edge();
        checks++;
        if (led3 !== 3'b000) begin
            failures++;
            $display("FAIL addr_out_of_range led3=%b expected=000", led3);
        end
        wr_en3   = 1'b1;
        wr_addr3 = 2'd1;
        clock_edge();
        wr_en3 = 1'b0;
        clock_edge();
        checks++;
        if (led3 !== 3'b010) begin
            failures++;
            $display("FAIL addr_in_range led3=%b expected=010", led3);
        end
    endtask

    task automatic test_midop_reset();
        bit found = 1'b0;
        do_reset();
        write_mode(2'd0, 2'b10);
        for (int k = 0; k < 20 && !found; k++) begin
            clock_edge();
            if (led[0] === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midop_wait led0 never rose within 20 cycles");
        end
        reset = 1'b0;
        clock_edge();
        checks++;
        if (led !== 4'h0 || blink_tick !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset led=%h tick=%b expected led=0 tick=0", led, blink_tick);
        end
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            clock_edge();
            checks++;
            if (blink_tick !== (k == 4)) begin
                failures++;
                $display("FAIL midop_first_tick edge=%0d tick=%b expected=%b", k, blink_tick, (k == 4));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 39) != 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 2'($urandom_range(0, 3));
            wr_mode    = 2'($urandom_range(0, 3));
            brightness = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) s = 4'($urandom_range(0, 15));
            clock_edge();
            checks++;
            if (led !== exp_led || blink_tick !== exp_tick) begin
                failures++;
                $display("FAIL random cyc=%0d led=%h tick=%b expected led=%h tick=%b",
                         k, led, blink_tick, exp_led, exp_tick);
            end
        end
        reset      = 1'b1;
        wr_en      = 1'b0;
        brightness = 2'd3;
        s          = 4'h0;
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        int highs = 0;
        do_reset();
        brightness = 2'd2;
        write_mode(2'd1, 2'b01);
        clock_edge();
        for (int k = 0; k < 8; k++) begin
            clock_edge();
            if (led[1]) highs++;
            checks++;
            if (led !== exp_led) begin
                failures++;
                $display("FAIL pwm_model cyc=%0d led=%h expected=%h", k, led, exp_led);
            end
        end
        checks++;
        if (highs != 4) begin
            failures++;
            $display("FAIL pwm_duty highs=%0d expected=4", highs);
        end
        brightness = 2'd0;
        for (int k = 0; k < 8; k++) begin
            clock_edge();
            checks++;
            if (led[1] !== 1'b0) begin
                failures++;
                $display("FAIL pwm_zero cyc=%0d led1=%b expected=0", k, led[1]);
            end
        end
        brightness = 2'd3;
    endtask
`endif

    initial begin
        reset       = 1'b0;
        s           = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_mode     = '0;
        brightness  = 2'd3;
        s3          = '0;
        wr_en3      = 1'b0;
        wr_addr3    = '0;
        wr_mode3    = '0;
        brightness3 = 2'd3;
        sq          = '{4'h0, 4'h0};
        n           = 0;
        exp_led     = '0;
        exp_tick    = 1'b0;
        for (int i = 0; i < N; i++) m_mode[i] = 2'b00;

        test_reset();
        test_blink();
        test_follow();
        test_addr_range();
        test_midop_reset();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
